// File: rtl/ad1_multi_reader.sv
// Multi-lane SPI reader for AD7476-class ADCs: shared CS/SCLK derived from clk,
// one SDATA lane per channel, single-shot or continuous framing.
`timescale 1ns/1ps
module ad1_multi_reader #(
    parameter int CHANNELS  = 2,
    parameter int DATA_W    = 12,
    parameter int LEAD_BITS = 4,
    parameter int HALF_DIV  = 2,
    parameter int QUIET_CYC = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         SCLK,
    output logic                         CS,
    input  logic [CHANNELS-1:0]          SDATA,
    input  logic                         getData,
    input  logic                         continuous,
    input  logic [CHANNELS-1:0]          activeCH,
    output logic                         busy,
    output logic                         data_valid,
    output logic                         missed,
    output logic [CHANNELS*DATA_W-1:0]   data
);
    localparam int FRAME_BITS = LEAD_BITS + DATA_W;
    localparam int BIT_W      = $clog2(FRAME_BITS + 1);
    localparam int DIV_W      = $clog2(HALF_DIV + 1);
    localparam int Q_W        = $clog2(QUIET_CYC + 1);

    typedef enum logic [1:0] {IDLE, FRAME, QUIET} state_t;

    state_t                state_reg, state_next;
    logic [DIV_W-1:0]      div_reg, div_next;
    logic [BIT_W-1:0]      bit_reg, bit_next;
    logic [Q_W-1:0]        quiet_reg, quiet_next;
    logic                  sclk_reg, sclk_next;
    logic                  cs_reg, cs_next;
    logic                  busy_reg, busy_next;
    logic                  valid_reg, valid_next;
    logic                  missed_reg, missed_next;
    logic [CHANNELS-1:0]   mask_reg, mask_next;

    logic half_done, rise, last_rise, last_quiet, start;

    assign half_done  = (div_reg == DIV_W'(HALF_DIV - 1));
    // A rise is the half-period boundary reached while SCLK is low.
    assign rise       = (state_reg == FRAME) && half_done && !sclk_reg;
    assign last_rise  = rise && (bit_reg == BIT_W'(FRAME_BITS - 1));
    assign last_quiet = (state_reg == QUIET) && (quiet_reg == Q_W'(QUIET_CYC - 1));

    always_comb begin
        state_next  = state_reg;
        div_next    = div_reg;
        bit_next    = bit_reg;
        quiet_next  = quiet_reg;
        sclk_next   = sclk_reg;
        cs_next     = cs_reg;
        busy_next   = busy_reg;
        valid_next  = 1'b0;
        mask_next   = mask_reg;
        start       = 1'b0;
        // The last quiet cycle hands a pending request over to IDLE instead.
        missed_next = getData && busy_reg && !last_quiet;
        case (state_reg)
            IDLE: begin
                sclk_next = 1'b1;
                cs_next   = 1'b1;
                if (getData || continuous) begin
                    start = 1'b1;
                end
            end
            FRAME: begin
                if (half_done) begin
                    div_next  = '0;
                    sclk_next = !sclk_reg;
                    if (rise) begin
                        bit_next = bit_reg + BIT_W'(1);
                    end
                    if (last_rise) begin
                        cs_next    = 1'b1;
                        valid_next = 1'b1;
                        quiet_next = '0;
                        state_next = QUIET;
                    end
                end else begin
                    div_next = div_reg + DIV_W'(1);
                end
            end
            QUIET: begin
                if (last_quiet) begin
                    if (continuous) begin
                        start = 1'b1;
                    end else begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                    end
                end else begin
                    quiet_next = quiet_reg + Q_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (start) begin
            state_next = FRAME;
            cs_next    = 1'b0;
            sclk_next  = 1'b1;
            busy_next  = 1'b1;
            mask_next  = activeCH;
            div_next   = '0;
            bit_next   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            div_reg    <= '0;
            bit_reg    <= '0;
            quiet_reg  <= '0;
            sclk_reg   <= 1'b1;
            cs_reg     <= 1'b1;
            busy_reg   <= 1'b0;
            valid_reg  <= 1'b0;
            missed_reg <= 1'b0;
            mask_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            div_reg    <= div_next;
            bit_reg    <= bit_next;
            quiet_reg  <= quiet_next;
            sclk_reg   <= sclk_next;
            cs_reg     <= cs_next;
            busy_reg   <= busy_next;
            valid_reg  <= valid_next;
            missed_reg <= missed_next;
            mask_reg   <= mask_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
            // Last DATA_W samples, including the bit captured on this edge.
            logic [DATA_W-1:0] sample_word;
            logic [DATA_W-1:0] lane_reg;
            if (DATA_W == 1) begin : g_narrow
                assign sample_word = SDATA[gi];
            end else begin : g_wide
                logic [DATA_W-2:0] shift_reg;
                always_ff @(posedge clk) begin
                    if (rst || start) begin
                        shift_reg <= '0;
                    end else if (rise) begin
                        shift_reg <= sample_word[DATA_W-2:0];
                    end
                end
                assign sample_word = {shift_reg, SDATA[gi]};
            end
            always_ff @(posedge clk) begin
                if (rst) begin
                    lane_reg <= '0;
                end else if (last_rise && mask_reg[gi]) begin
                    lane_reg <= sample_word;
                end
            end
            assign data[gi*DATA_W +: DATA_W] = lane_reg;
        end
    endgenerate

    assign SCLK       = sclk_reg;
    assign CS         = cs_reg;
    assign busy       = busy_reg;
    assign data_valid = valid_reg;
    assign missed     = missed_reg;
endmodule

// File: tb/tb_ad1_multi_reader.sv
// Bench for ad1_multi_reader: ADC lane models, a frame-phase reference model
// checked every cycle, and directed frame measurements with literal expectations.
`timescale 1ns/1ps
module tb_ad1_multi_reader;
    localparam int FC = 64;
    localparam int QC = 3;
    localparam int HD = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        get_a = 1'b0, cont_a = 1'b0;
    logic [1:0]  act_a = 2'b11;
    logic [1:0]  sd_a = 2'b00;
    logic        sclk_a, cs_a, busy_a, dv_a, miss_a;
    logic [23:0] data_a;

    logic        get_b = 1'b0;
    logic [0:0]  sd_b = 1'b0;
    logic        sclk_b, cs_b, busy_b, dv_b, miss_b;
    logic [13:0] data_b;

    logic [11:0] adc_a [2];
    logic [13:0] adc_b;
    logic [15:0] word0, word1, word_b;
    int          idx_a = 0, idx_b = 0;

    int checks = 0, errors = 0;
    bit chk_en = 1'b0;

    ad1_multi_reader dut_a (
        .clk(clk), .rst(rst), .SCLK(sclk_a), .CS(cs_a), .SDATA(sd_a),
        .getData(get_a), .continuous(cont_a), .activeCH(act_a),
        .busy(busy_a), .data_valid(dv_a), .missed(miss_a), .data(data_a)
    );

    ad1_multi_reader #(
        .CHANNELS(1), .DATA_W(14), .LEAD_BITS(2), .HALF_DIV(1), .QUIET_CYC(3)
    ) dut_b (
        .clk(clk), .rst(rst), .SCLK(sclk_b), .CS(cs_b), .SDATA(sd_b),
        .getData(get_b), .continuous(1'b0), .activeCH(1'b1),
        .busy(busy_b), .data_valid(dv_b), .missed(miss_b), .data(data_b)
    );

    // ADC models: leading zeros, then the value MSB first, one bit per SCLK fall.
    always @(negedge cs_a) idx_a = 0;
    always @(negedge sclk_a) begin
        if (idx_a < 16) begin
            word0 = {4'b0, adc_a[0]};
            word1 = {4'b0, adc_a[1]};
            sd_a  = {word1[15-idx_a], word0[15-idx_a]};
            idx_a++;
        end
    end
    always @(negedge cs_b) idx_b = 0;
    always @(negedge sclk_b) begin
        if (idx_b < 16) begin
            word_b = {2'b0, adc_b};
            sd_b   = word_b[15-idx_b];
            idx_b++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model for dut_a: m_p counts edges since CS fell (-1 = idle).
    int          m_p = -1;
    logic [1:0]  m_mask = 2'b00;
    logic [11:0] m_snap [2];
    logic [23:0] m_data = 24'h0;
    bit          m_valid = 1'b0, m_missed = 1'b0;

    function void model_start();
        m_p       = 0;
        m_mask    = act_a;
        m_snap[0] = adc_a[0];
        m_snap[1] = adc_a[1];
    endfunction

    function automatic logic exp_sclk(input int p);
        if (p < HD || p >= FC) return 1'b1;
        return ((p / HD) % 2) == 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_p = -1; m_data = 24'h0; m_valid = 1'b0; m_missed = 1'b0;
        end else begin
            m_missed = get_a && (m_p >= 0) && (m_p != FC + QC - 1);
            m_valid  = 1'b0;
            if (m_p == -1) begin
                if (get_a || cont_a) model_start();
            end else if (m_p == FC - 1) begin
                m_p = FC;
                m_valid = 1'b1;
                for (int i = 0; i < 2; i++)
                    if (m_mask[i]) m_data[i*12 +: 12] = m_snap[i];
            end else if (m_p == FC + QC - 1) begin
                if (cont_a) model_start();
                else m_p = -1;
            end else begin
                m_p++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en)
            check("cycle_a", {3'b0, cs_a, sclk_a, busy_a, dv_a, miss_a, data_a},
                  {3'b0, !(m_p >= 0 && m_p < FC), exp_sclk(m_p), (m_p >= 0), m_valid, m_missed, m_data});
    end

    // Fires one getData pulse and samples until busy returns low.
    task automatic measure(input bit use_b, input int miss_at,
                           output int cs_low, output int falls, output int dv_n,
                           output int tail, output int miss_n, output bit dv_rise);
        bit prev_sclk = 1'b1, prev_cs = 1'b1, seen = 1'b0, done = 1'b0;
        bit c_cs, c_sclk, c_busy, c_dv, c_miss;
        cs_low = 0; falls = 0; dv_n = 0; tail = 0; miss_n = 0; dv_rise = 1'b0;
        if (use_b) get_b = 1'b1; else get_a = 1'b1;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            c_cs   = use_b ? cs_b   : cs_a;
            c_sclk = use_b ? sclk_b : sclk_a;
            c_busy = use_b ? busy_b : busy_a;
            c_dv   = use_b ? dv_b   : dv_a;
            c_miss = use_b ? miss_b : miss_a;
            if (!c_cs) cs_low++;
            if (prev_sclk && !c_sclk) falls++;
            if (c_dv) begin
                dv_n++;
                if (c_cs && !prev_cs) dv_rise = 1'b1;
            end
            if (c_busy && c_cs) tail++;
            if (c_miss) miss_n++;
            if (c_busy) seen = 1'b1;
            else if (seen) done = 1'b1;
            prev_sclk = c_sclk;
            prev_cs   = c_cs;
            if (use_b) get_b = 1'b0; else get_a = (c == miss_at);
        end
        get_a = 1'b0;
        check(use_b ? "frame_done_b" : "frame_done_a", 32'(done), 32'd1);
    endtask

    int cs_low, falls, dv_n, tail, miss_n;
    bit dv_rise;
    int t [3];
    int nf, ndv;
    bit pc;

    initial begin
        adc_a[0] = 12'hA5C;
        adc_a[1] = 12'h3F1;
        adc_b    = 14'h2ABC;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_cs",     32'(cs_a),   32'd1);
        check("reset_sclk",   32'(sclk_a), 32'd1);
        check("reset_busy",   32'(busy_a), 32'd0);
        check("reset_valid",  32'(dv_a),   32'd0);
        check("reset_missed", 32'(miss_a), 32'd0);
        check("reset_data",   32'(data_a), 32'h0);
        check("reset_data_b", 32'(data_b), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        measure(1'b0, -1, cs_low, falls, dv_n, tail, miss_n, dv_rise);
        $display("single frame: cs_low=%0d falls=%0d dv=%0d tail=%0d data=%h", cs_low, falls, dv_n, tail, data_a);
        check("t1_cs_low", 32'(cs_low), 32'd64);
        check("t1_falls",  32'(falls),  32'd16);
        check("t1_dv",     32'(dv_n),   32'd1);
        check("t1_dvrise", 32'(dv_rise), 32'd1);
        check("t1_tail",   32'(tail),   32'd3);
        check("t1_data",   32'(data_a), 32'h3F1A5C);
        repeat (5) @(negedge clk);

        act_a = 2'b01; adc_a[0] = 12'h123; adc_a[1] = 12'hFFF;
        measure(1'b0, -1, cs_low, falls, dv_n, tail, miss_n, dv_rise);
        $display("masked frame: data=%h", data_a);
        check("t2_data", 32'(data_a), 32'h3F1123);
        repeat (5) @(negedge clk);

        cont_a = 1'b1; nf = 0; ndv = 0; pc = 1'b1; t = '{default: 0};
        for (int c = 0; c < 420; c++) begin
            @(negedge clk);
            if (pc && !cs_a) begin
                if (nf < 3) t[nf] = c;
                nf++;
            end
            if (dv_a) ndv++;
            pc = cs_a;
            if (nf == 3 && c == t[2] + 10) cont_a = 1'b0;
        end
        cont_a = 1'b0;
        $display("continuous: falls=%0d at %0d %0d %0d, dv=%0d", nf, t[0], t[1], t[2], ndv);
        check("cont_falls",   32'(nf),          32'd3);
        check("cont_period1", 32'(t[1] - t[0]), 32'd67);
        check("cont_period2", 32'(t[2] - t[1]), 32'd67);
        check("cont_dv",      32'(ndv),         32'd3);
        repeat (5) @(negedge clk);

        measure(1'b0, 20, cs_low, falls, dv_n, tail, miss_n, dv_rise);
        repeat (10) @(negedge clk);
        $display("missed frame: missed=%0d cs_low=%0d data=%h", miss_n, cs_low, data_a);
        check("miss_count",  32'(miss_n), 32'd1);
        check("miss_cs_low", 32'(cs_low), 32'd64);
        check("miss_idle",   32'(busy_a), 32'd0);
        check("miss_data",   32'(data_a), 32'h3F1123);

        act_a = 2'b11;
        get_a = 1'b1;
        @(negedge clk);
        get_a = 1'b0;
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("mid-frame reset: cs=%b sclk=%b busy=%b dv=%b data=%h", cs_a, sclk_a, busy_a, dv_a, data_a);
        check("rst_cs",    32'(cs_a),   32'd1);
        check("rst_sclk",  32'(sclk_a), 32'd1);
        check("rst_busy",  32'(busy_a), 32'd0);
        check("rst_valid", 32'(dv_a),   32'd0);
        check("rst_data",  32'(data_a), 32'h0);
        repeat (3) @(negedge clk);
        measure(1'b0, -1, cs_low, falls, dv_n, tail, miss_n, dv_rise);
        $display("post-reset frame: dv=%0d data=%h", dv_n, data_a);
        check("post_rst_dv",   32'(dv_n),   32'd1);
        check("post_rst_data", 32'(data_a), 32'hFFF123);
        repeat (5) @(negedge clk);

        measure(1'b1, -1, cs_low, falls, dv_n, tail, miss_n, dv_rise);
        $display("narrow config: cs_low=%0d falls=%0d dv=%0d data=%h", cs_low, falls, dv_n, data_b);
        check("b_cs_low", 32'(cs_low), 32'd32);
        check("b_falls",  32'(falls),  32'd16);
        check("b_dv",     32'(dv_n),   32'd1);
        check("b_tail",   32'(tail),   32'd3);
        check("b_data",   32'(data_b), 32'h2ABC);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
